// File: rtl/uart_hex_tx_if.sv
// Word handshake and UART transmit-FIFO write port of uart_hex_tx.
// master drives words and FIFO status; slave is the hex formatter itself.
interface uart_hex_tx_if;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        tx_full;

    modport master (
        output word_in,
        output word_valid,
        output tx_full,
        input  word_ready,
        input  w_data,
        input  wr_uart
    );

    modport slave (
        input  word_in,
        input  word_valid,
        input  tx_full,
        output word_ready,
        output w_data,
        output wr_uart
    );
endinterface

// File: rtl/uart_hex_tx.sv
// Formats a 16-bit word as four uppercase ASCII hex characters (optionally CR LF)
// and writes them one per cycle into a UART transmit FIFO, honouring FIFO-full backpressure.
module uart_hex_tx #(
    parameter int unsigned SEND_CRLF = 1
) (
    input  logic         clk,
    input  logic         reset,
    uart_hex_tx_if.slave bus,
    output logic         busy,
    output logic [15:0]  words_sent
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [15:0] words_sent_q, words_sent_d;
    logic [3:0]  nibble;
    logic [7:0]  char;
    logic        wr;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        nibble = 4'h0;
        case (idx_q[1:0])
            2'd0:    nibble = word_q[15:12];
            2'd1:    nibble = word_q[11:8];
            2'd2:    nibble = word_q[7:4];
            default: nibble = word_q[3:0];
        endcase
    end

    always_comb begin
        char = 8'h00;
        if (state_q == ST_SEND) begin
            case (idx_q)
                3'd0, 3'd1, 3'd2, 3'd3: char = hex_ascii(nibble);
                3'd4: if (SEND_CRLF != 0) char = 8'h0D;
                3'd5: if (SEND_CRLF != 0) char = 8'h0A;
                default: char = 8'h00;
            endcase
        end
    end

    // Reset gates the strobes combinationally so an abandoned word never leaks a byte.
    assign wr             = (state_q == ST_SEND) && !bus.tx_full && !reset;
    assign bus.wr_uart    = wr;
    assign bus.w_data     = char;
    assign bus.word_ready = (state_q == ST_IDLE) && !reset;
    assign busy           = (state_q == ST_SEND);
    assign words_sent     = words_sent_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        words_sent_d = words_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.word_valid) begin
                    word_d  = bus.word_in;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (wr) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        idx_d        = 3'd0;
                        words_sent_d = words_sent_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            word_q       <= 16'h0000;
            words_sent_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            words_sent_q <= words_sent_d;
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Scoreboard bench for uart_hex_tx: one instance with CR/LF, one without.
module tb_uart_hex_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_hex_tx_if a_if ();
    uart_hex_tx_if b_if ();

    logic        a_busy, b_busy;
    logic [15:0] a_sent, b_sent;

    uart_hex_tx #(.SEND_CRLF(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (a_if),
        .busy       (a_busy),
        .words_sent (a_sent)
    );

    uart_hex_tx #(.SEND_CRLF(0)) dut_nocrlf (
        .clk        (clk),
        .reset      (reset),
        .bus        (b_if),
        .busy       (b_busy),
        .words_sent (b_sent)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] ea, eb;
    int a_wr_cnt = 0, b_wr_cnt = 0;
    int a_last_wr = -1, b_last_wr = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_hex(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    function automatic void push_a(input logic [15:0] w);
        exp_a.push_back(model_hex(w[15:12]));
        exp_a.push_back(model_hex(w[11:8]));
        exp_a.push_back(model_hex(w[7:4]));
        exp_a.push_back(model_hex(w[3:0]));
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endfunction

    // Scoreboard monitors: every write strobe pops one expected byte.
    always @(negedge clk) begin
        if (a_if.wr_uart === 1'b1) begin
            a_wr_cnt++;
            a_last_wr = cyc;
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_write: got w_data=%h, required no write", a_if.w_data);
            end else begin
                ea = exp_a.pop_front();
                if (a_if.w_data !== ea) begin
                    bad++;
                    $display("FAIL a_byte: got %h, required %h (cyc %0d)", a_if.w_data, ea, cyc);
                end
            end
        end
        if (b_if.wr_uart === 1'b1) begin
            b_wr_cnt++;
            b_last_wr = cyc;
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_write: got w_data=%h, required no write", b_if.w_data);
            end else begin
                eb = exp_b.pop_front();
                if (b_if.w_data !== eb) begin
                    bad++;
                    $display("FAIL b_byte: got %h, required %h (cyc %0d)", b_if.w_data, eb, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a(output int rc);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_if.word_ready === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        total++;
        if (rc < 0) begin
            bad++;
            $display("FAIL a_ready_timeout: got no word_ready, required word_ready=1 within 40");
        end
    endtask

    task automatic wait_ready_b(output int rc);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_if.word_ready === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        total++;
        if (rc < 0) begin
            bad++;
            $display("FAIL b_ready_timeout: got no word_ready, required word_ready=1 within 40");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({a_if.word_ready, a_if.wr_uart, b_if.word_ready, b_if.wr_uart} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes: got %b, required 0000",
                     {a_if.word_ready, a_if.wr_uart, b_if.word_ready, b_if.wr_uart});
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({a_if.word_ready, a_busy, b_if.word_ready, b_busy} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_release_ready: got %b, required 1010",
                     {a_if.word_ready, a_busy, b_if.word_ready, b_busy});
        end
        total++;
        if (a_sent !== 16'h0000 || b_sent !== 16'h0000 || a_if.w_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: got sent=%h/%h w_data=%h, required 0000/0000 00",
                     a_sent, b_sent, a_if.w_data);
        end
    endtask

    task automatic test_basic();
        int n, rc, c0;
        step();
        a_if.word_in    = 16'h1A2F;
        a_if.word_valid = 1'b1;
        push_a(16'h1A2F);
        @(negedge clk);
        n  = cyc;
        c0 = a_wr_cnt;
        total++;
        if (a_if.word_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready: got %b, required 1", a_if.word_ready);
        end
        step();
        a_if.word_valid = 1'b0;
        a_if.word_in    = 16'hFFFF;
        wait_ready_a(rc);
        total++;
        if (rc !== n + 7) begin
            bad++;
            $display("FAIL basic_ready_cycle: got %0d, required %0d", rc, n + 7);
        end
        total++;
        if (a_last_wr !== n + 6 || a_wr_cnt - c0 !== 6) begin
            bad++;
            $display("FAIL basic_writes: got last=%0d cnt=%0d, required last=%0d cnt=6",
                     a_last_wr, a_wr_cnt - c0, n + 6);
        end
        total++;
        if (a_sent !== 16'd1) begin
            bad++;
            $display("FAIL basic_words_sent: got %0d, required 1", a_sent);
        end
    endtask

    task automatic test_backpressure();
        int n, rc, c0;
        step();
        a_if.word_in    = 16'hBEEF;
        a_if.word_valid = 1'b1;
        push_a(16'hBEEF);
        @(negedge clk);
        n  = cyc;
        c0 = a_wr_cnt;
        step();
        a_if.word_valid = 1'b0;
        step();
        a_if.tx_full = 1'b1;
        @(negedge clk);
        total++;
        if (a_if.wr_uart !== 1'b0 || a_if.w_data !== 8'h45) begin
            bad++;
            $display("FAIL bp_hold: got wr=%b w_data=%h, required wr=0 w_data=45",
                     a_if.wr_uart, a_if.w_data);
        end
        step();
        step();
        step();
        a_if.tx_full = 1'b0;
        wait_ready_a(rc);
        total++;
        if (a_last_wr !== n + 9 || a_wr_cnt - c0 !== 6) begin
            bad++;
            $display("FAIL bp_final_write: got last=%0d cnt=%0d, required last=%0d cnt=6",
                     a_last_wr, a_wr_cnt - c0, n + 9);
        end
        total++;
        if (rc !== n + 10 || a_sent !== 16'd2) begin
            bad++;
            $display("FAIL bp_done: got ready_cyc=%0d sent=%0d, required %0d 2", rc, a_sent, n + 10);
        end
    endtask

    task automatic test_midword_reset();
        int c0;
        step();
        a_if.word_in    = 16'h1234;
        a_if.word_valid = 1'b1;
        exp_a.push_back(8'h31);
        exp_a.push_back(8'h32);
        @(negedge clk);
        c0 = a_wr_cnt;
        step();
        a_if.word_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (a_if.wr_uart !== 1'b0 || a_if.word_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_strobes: got wr=%b ready=%b, required 0 0",
                     a_if.wr_uart, a_if.word_ready);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (a_if.word_ready !== 1'b1 || a_busy !== 1'b0 || a_sent !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset_after: got ready=%b busy=%b sent=%0d, required 1 0 0",
                     a_if.word_ready, a_busy, a_sent);
        end
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        total++;
        if (a_wr_cnt - c0 !== 2) begin
            bad++;
            $display("FAIL mid_reset_writes: got %0d, required 2", a_wr_cnt - c0);
        end
    endtask

    task automatic test_ignored_valid();
        int n, rc, c0;
        step();
        a_if.word_valid = 1'b1;
        a_if.word_in    = 16'hC0DE;
        push_a(16'hC0DE);
        @(negedge clk);
        n  = cyc;
        c0 = a_wr_cnt;
        for (int k = 1; k <= 6; k++) begin
            step();
            a_if.word_in = 16'($urandom);
        end
        step();
        a_if.word_in = 16'h5A03;
        push_a(16'h5A03);
        for (int k = 8; k <= 13; k++) begin
            step();
            a_if.word_in = 16'($urandom);
        end
        step();
        a_if.word_valid = 1'b0;
        wait_ready_a(rc);
        total++;
        if (rc !== n + 14 || a_last_wr !== n + 13 || a_wr_cnt - c0 !== 12) begin
            bad++;
            $display("FAIL ignored_valid: got ready=%0d last=%0d cnt=%0d, required %0d %0d 12",
                     rc, a_last_wr, a_wr_cnt - c0, n + 14, n + 13);
        end
        total++;
        if (a_sent !== 16'd2) begin
            bad++;
            $display("FAIL ignored_valid_sent: got %0d, required 2", a_sent);
        end
    endtask

    task automatic send_word_a(input logic [15:0] w);
        int rc;
        step();
        a_if.word_in    = w;
        a_if.word_valid = 1'b1;
        push_a(w);
        step();
        a_if.word_valid = 1'b0;
        wait_ready_a(rc);
    endtask

    task automatic test_wrap();
        // Stand-in for 65534 earlier completions, which would take far too long to simulate.
        step();
        force dut.words_sent_q = 16'hFFFE;
        step();
        release dut.words_sent_q;
        send_word_a(16'h00FF);
        total++;
        if (a_sent !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_pre: got %h, required FFFF", a_sent);
        end
        send_word_a(16'hABCD);
        total++;
        if (a_sent !== 16'h0000) begin
            bad++;
            $display("FAIL wrap: got %h, required 0000", a_sent);
        end
    endtask

    task automatic test_nocrlf();
        int n, rc, c0;
        step();
        b_if.word_in    = 16'h0009;
        b_if.word_valid = 1'b1;
        exp_b.push_back(8'h30);
        exp_b.push_back(8'h30);
        exp_b.push_back(8'h30);
        exp_b.push_back(8'h39);
        @(negedge clk);
        n  = cyc;
        c0 = b_wr_cnt;
        step();
        b_if.word_valid = 1'b0;
        wait_ready_b(rc);
        total++;
        if (rc !== n + 5 || b_last_wr !== n + 4 || b_wr_cnt - c0 !== 4) begin
            bad++;
            $display("FAIL nocrlf_timing: got ready=%0d last=%0d cnt=%0d, required %0d %0d 4",
                     rc, b_last_wr, b_wr_cnt - c0, n + 5, n + 4);
        end
        total++;
        if (b_sent !== 16'd1) begin
            bad++;
            $display("FAIL nocrlf_sent: got %0d, required 1", b_sent);
        end
    endtask

    initial begin
        reset           = 1'b1;
        a_if.word_in    = 16'h0000;
        a_if.word_valid = 1'b0;
        a_if.tx_full    = 1'b0;
        b_if.word_in    = 16'h0000;
        b_if.word_valid = 1'b0;
        b_if.tx_full    = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_nocrlf();
        test_midword_reset();
        test_ignored_valid();
        test_wrap();
        for (int i = 0; i < 3; i++) step();
        total++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            bad++;
            $display("FAIL leftover_bytes: got %0d/%0d pending, required 0/0",
                     exp_a.size(), exp_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
